// File: rtl/sp_boot_pkg.sv
// Shared types and 48 MHz timing defaults for the boot/reset controller.
package sp_boot_pkg;

    // Exit sequencer states; encoding is visible on state_dbg.
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_DETACH  = 2'b01,
        ST_PROGRAM = 2'b10,
        ST_HOLD    = 2'b11
    } exit_state_t;

    localparam int DEF_NUM_BTN       = 7;
    localparam int DEF_RST_BTN       = 1;
    localparam int DEF_DB_CYCLES     = 65536;     // ~1.4 ms
    localparam int DEF_RST_HOLD      = 32768;     // ~0.7 ms
    localparam int DEF_LONG_CYCLES   = 96000000;  // 2 s
    localparam int DEF_DETACH_CYCLES = 4800000;   // 100 ms
    localparam int DEF_PROG_CYCLES   = 4800;      // 100 us

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sp_btn_debounce.sv
// One button: two-flop synchroniser, stability-counter debouncer and
// registered one-cycle pulse on each debounced rising edge.
module sp_btn_debounce
    import sp_boot_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic btn,
    output logic btn_db,
    output logic btn_press
);

    localparam int             CW      = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          db_q;
    logic          db_prev;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed from btn_db long enough.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            cnt  <= '0;
            db_q <= 1'b0;
        end else if (sync2 == db_q) begin
            cnt <= '0;
        end else if (cnt == DB_LAST) begin
            cnt  <= '0;
            db_q <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Pulse for one cycle, one cycle after btn_db rises.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            db_prev   <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            db_prev   <= db_q;
            btn_press <= db_q & ~db_prev;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/sp_boot_reset_ctrl.sv
// Button conditioning, core reset stretcher, long-press detector and the
// USB-detach-then-PROGRAMN exit sequencer for the bootloader top.
module sp_boot_reset_ctrl
    import sp_boot_pkg::*;
#(
    parameter int NUM_BTN       = DEF_NUM_BTN,
    parameter int RST_BTN       = DEF_RST_BTN,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int RST_HOLD      = DEF_RST_HOLD,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int DETACH_CYCLES = DEF_DETACH_CYCLES,
    parameter int PROG_CYCLES   = DEF_PROG_CYCLES
) (
    input  logic               clk_48mhz,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               boot,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               core_reset,
    output logic               usb_pu_en,
    output logic               usb_force_se0,
    output logic               user_programn,
    output logic [1:0]         state_dbg
);

    localparam int RW = $clog2(RST_HOLD) + 1;
    localparam int LW = $clog2(LONG_CYCLES) + 1;
    localparam int TW = $clog2(max2(DETACH_CYCLES, PROG_CYCLES)) + 1;

    localparam logic [RW-1:0] RST_M1  = RW'(RST_HOLD - 1);
    localparam logic [RW-1:0] RST_MAX = RW'(RST_HOLD);
    localparam logic [LW-1:0] LONG_M1 = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MX = LW'(LONG_CYCLES);
    localparam logic [TW-1:0] DET_M1  = TW'(DETACH_CYCLES - 1);
    localparam logic [TW-1:0] PROG_M1 = TW'(PROG_CYCLES - 1);
    localparam logic [TW-1:0] TMR_MAX = TW'(max2(DETACH_CYCLES, PROG_CYCLES));

    exit_state_t   state_q;
    exit_state_t   state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [RW-1:0] stretch_cnt;
    logic          stretch_q;
    logic [LW-1:0] hold_cnt;
    logic          rst_cause;
    logic          long_req;
    logic          boot_req;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        sp_btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk_48mhz (clk_48mhz),
            .reset     (reset),
            .btn       (btn[i]),
            .btn_db    (btn_db[i]),
            .btn_press (btn_press[i])
        );
    end

    // Anything that must keep the core in reset right now.
    assign rst_cause  = btn_db[RST_BTN] | (state_q != ST_RUN);
    // Causes act immediately; the registered tail keeps reset for RST_HOLD more cycles.
    assign core_reset = rst_cause | stretch_q;

    // Reset tail counter: held at 0 while a cause is present, saturates at RST_HOLD.
    always_ff @(posedge clk_48mhz) begin
        if (reset || rst_cause) begin
            stretch_cnt <= '0;
            stretch_q   <= 1'b1;
        end else if (stretch_cnt != RST_MAX) begin
            stretch_cnt <= stretch_cnt + RW'(1);
            stretch_q   <= (stretch_cnt != RST_M1);
        end
    end

    // Long-press hold counter; saturation makes the request fire once per press.
    always_ff @(posedge clk_48mhz) begin
        if (reset || !btn_db[RST_BTN]) begin
            hold_cnt <= '0;
        end else if (hold_cnt != LONG_MX) begin
            hold_cnt <= hold_cnt + LW'(1);
        end
    end

    // Request is live in the cycle the hold count steps onto LONG_CYCLES.
    assign long_req = btn_db[RST_BTN] && (hold_cnt == LONG_M1);
    // A boot request from a core that is still in reset is not trusted.
    assign boot_req = boot && !core_reset;

    // Exit sequencer state and phase timer.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q <= ST_RUN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Exit sequencer next state: RUN -> DETACH -> PROGRAM -> HOLD (terminal).
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q != TMR_MAX) ? timer_q + TW'(1) : timer_q;
        case (state_q)
            ST_RUN: begin
                timer_d = '0;
                if (boot_req || long_req) state_d = ST_DETACH;
            end
            ST_DETACH: begin
                if (timer_q == DET_M1) begin
                    state_d = ST_PROGRAM;
                    timer_d = '0;
                end
            end
            ST_PROGRAM: begin
                if (timer_q == PROG_M1) begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                end
            end
            ST_HOLD: begin
                timer_d = '0;
            end
            default: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
        endcase
    end

    assign usb_force_se0 = core_reset;
    assign usb_pu_en     = ~core_reset & (state_q == ST_RUN);
    assign user_programn = ~((state_q == ST_PROGRAM) || (state_q == ST_HOLD));
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_sp_boot_reset_ctrl.sv
// Event scoreboard bench for sp_boot_reset_ctrl: every change of the output
// vector must match the next expected (cycle, value) entry.
module tb_sp_boot_reset_ctrl;

    logic       clk_48mhz;
    logic       reset;
    logic [1:0] btn;
    logic       boot;
    logic [1:0] btn_db;
    logic [1:0] btn_press;
    logic       core_reset;
    logic       usb_pu_en;
    logic       usb_force_se0;
    logic       user_programn;
    logic [1:0] state_dbg;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [25:0] exp_q[$];
    logic [25:0] exp_e;
    logic [9:0]  cur_vec;
    logic [9:0]  prev_vec = 'x;

    sp_boot_reset_ctrl #(
        .NUM_BTN       (2),
        .RST_BTN       (1),
        .DB_CYCLES     (4),
        .RST_HOLD      (16),
        .LONG_CYCLES   (64),
        .DETACH_CYCLES (8),
        .PROG_CYCLES   (4)
    ) dut (
        .clk_48mhz     (clk_48mhz),
        .reset         (reset),
        .btn           (btn),
        .boot          (boot),
        .btn_db        (btn_db),
        .btn_press     (btn_press),
        .core_reset    (core_reset),
        .usb_pu_en     (usb_pu_en),
        .usb_force_se0 (usb_force_se0),
        .user_programn (user_programn),
        .state_dbg     (state_dbg)
    );

    // Clock and cycle counter (cyc = number of rising edges so far).
    initial clk_48mhz = 1'b0;
    always #5 clk_48mhz = ~clk_48mhz;
    always @(posedge clk_48mhz) cyc <= cyc + 1;

    // Output vector: {state, programn, se0, pu_en, core_reset, press[1:0], db[1:0]}.
    function automatic logic [9:0] mk(input logic [1:0] st, input logic pn, input logic se0,
                                      input logic pu, input logic cr,
                                      input logic [1:0] pr, input logic [1:0] db);
        return {st, pn, se0, pu, cr, pr, db};
    endfunction

    task automatic expect_at(input int c, input logic [9:0] v);
        exp_q.push_back({16'(c), v});
    endtask

    // Return 2 ns after edge k so inputs change away from the clock edge.
    task automatic at_cycle(input int k);
        while (cyc < k) begin
            @(posedge clk_48mhz);
            #2;
        end
    endtask

    // Monitor: on every output change, pop and compare cycle and value.
    always @(negedge clk_48mhz) begin
        if (cyc >= 1) begin
            cur_vec = {state_dbg, user_programn, usb_force_se0, usb_pu_en, core_reset,
                       btn_press, btn_db};
            if (cur_vec !== prev_vec) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no change",
                             cyc, cur_vec);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (exp_e[25:10] != 16'(cyc) || exp_e[9:0] !== cur_vec) begin
                        errors++;
                        $display("FAIL event cyc=%0d got=%b required cyc=%0d vec=%b",
                                 cyc, cur_vec, exp_e[25:10], exp_e[9:0]);
                    end
                end
                prev_vec = cur_vec;
            end
        end
    end

    // Directed stimulus with hand-computed output events.
    initial begin
        logic [9:0] rst_v;
        logic [9:0] idle_v;
        rst_v  = mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
        idle_v = mk(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        reset = 1'b1;
        btn   = 2'b00;
        boot  = 1'b0;

        // Reset values, then 16-cycle stretch after release.
        expect_at(1, rst_v);
        expect_at(21, idle_v);
        at_cycle(5);  reset = 1'b0;

        // 3-cycle glitch on btn[0] must not show; 10-cycle press must.
        at_cycle(30); btn[0] = 1'b1;
        at_cycle(33); btn[0] = 1'b0;
        expect_at(46, mk(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01));
        expect_at(47, mk(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01));
        expect_at(48, mk(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01));
        expect_at(56, idle_v);
        at_cycle(40); btn[0] = 1'b1;
        at_cycle(50); btn[0] = 1'b0;

        // Short press of the reset button.
        expect_at(66, mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(67, mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10));
        expect_at(68, mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(86, rst_v);
        expect_at(102, idle_v);
        at_cycle(60); btn[1] = 1'b1;
        at_cycle(80); btn[1] = 1'b0;

        // Boot pulse: DETACH 8 cycles, PROGRAM 4, then HOLD; boot in HOLD and
        // boot during the post-reset stretch are both ignored.
        expect_at(111, mk(2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00));
        expect_at(119, mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00));
        expect_at(123, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00));
        expect_at(131, rst_v);
        expect_at(148, idle_v);
        at_cycle(110); boot = 1'b1;
        at_cycle(111); boot = 1'b0;
        at_cycle(125); boot = 1'b1;
        at_cycle(128); boot = 1'b0;
        at_cycle(130); reset = 1'b1;
        at_cycle(132); reset = 1'b0;
        at_cycle(135); boot = 1'b1;
        at_cycle(140); boot = 1'b0;

        // Long press: exit starts 64 cycles after btn_db[1] rises; second press ignored.
        expect_at(166, mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(167, mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10));
        expect_at(168, mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(230, mk(2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(238, mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(242, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(266, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00));
        expect_at(286, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(287, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10));
        expect_at(288, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10));
        expect_at(306, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00));
        at_cycle(160); btn[1] = 1'b1;
        at_cycle(260); btn[1] = 1'b0;
        at_cycle(280); btn[1] = 1'b1;
        at_cycle(300); btn[1] = 1'b0;

        // Reset asserted in PROGRAM returns everything to reset values.
        expect_at(321, rst_v);
        expect_at(337, idle_v);
        expect_at(341, mk(2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00));
        expect_at(349, mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00));
        expect_at(351, rst_v);
        expect_at(368, idle_v);
        at_cycle(320); reset = 1'b1;
        at_cycle(321); reset = 1'b0;
        at_cycle(340); boot = 1'b1;
        at_cycle(341); boot = 1'b0;
        at_cycle(350); reset = 1'b1;
        at_cycle(352); reset = 1'b0;

        // Any expected event that never happened is a failure.
        at_cycle(380);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event got=none required cyc=%0d vec=%b",
                     exp_e[25:10], exp_e[9:0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
